// File: rtl/wfg_mem_arbiter.sv
// Two-requester arbiter for the waveform SRAM read port with in-flight read tracking.
// Define WFG_MEM_ARB_RR_EN for round-robin on contention; otherwise requester 0 has fixed priority.
module wfg_mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              en_i,
    input  logic              req0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    output logic              gnt0_o,
    output logic              rvalid0_o,
    input  logic              req1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    output logic              gnt1_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o,
    output logic              csb1,
    output logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] dout1
);

    logic              issue;
    logic              sel1;
    logic              last_gnt;
    logic [RD_LAT:1]   vld_pipe;
    logic [RD_LAT:1]   own_pipe;

    assign issue = en_i & (req0_i | req1_i) & ~wb_rst_i;

`ifdef WFG_MEM_ARB_RR_EN
    // On contention hand the port to whoever did not win last time.
    assign sel1 = req1_i & (~req0_i | ~last_gnt);
`else
    assign sel1 = req1_i & ~req0_i;
`endif

    assign gnt0_o = issue & ~sel1;
    assign gnt1_o = issue & sel1;
    assign csb1   = ~issue;
    assign addr1  = issue ? (sel1 ? addr1_i : addr0_i) : '0;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            vld_pipe <= '0;
            own_pipe <= '0;
            last_gnt <= 1'b1;
        end else begin
            vld_pipe[1] <= issue;
            own_pipe[1] <= sel1;
            for (int i = 2; i <= RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                own_pipe[i] <= own_pipe[i-1];
            end
            last_gnt <= issue ? sel1 : last_gnt;
        end
    end

    // Gate with reset so a read caught by reset never reports back.
    assign rvalid0_o = vld_pipe[RD_LAT] & ~own_pipe[RD_LAT] & ~wb_rst_i;
    assign rvalid1_o = vld_pipe[RD_LAT] &  own_pipe[RD_LAT] & ~wb_rst_i;
    assign busy_o    = (|vld_pipe) & ~wb_rst_i;
    assign rdata_o   = dout1;

endmodule

// File: tb/tb_wfg_mem_arbiter.sv
// Vector-table and scoreboard bench for wfg_mem_arbiter with a behavioural SRAM read port.
module tb_wfg_mem_arbiter;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 1;

    logic clk = 1'b0;
    logic rst, en, req0, req1;
    logic [ADDR_W-1:0] a0, a1;
    logic gnt0, gnt1, rv0, rv1, busy, csb1;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] rdata, dout1;

    logic [DATA_W-1:0] mem [1024];
    logic [ADDR_W-1:0] ra  [RD_LAT];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wfg_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .en_i(en),
        .req0_i(req0), .addr0_i(a0), .gnt0_o(gnt0), .rvalid0_o(rv0),
        .req1_i(req1), .addr1_i(a1), .gnt1_o(gnt1), .rvalid1_o(rv1),
        .rdata_o(rdata), .busy_o(busy), .csb1(csb1), .addr1(sram_addr), .dout1(dout1)
    );

    // SRAM: address captured on the edge, data appears RD_LAT cycles after the select cycle.
    always @(posedge clk) begin
        ra[0] <= sram_addr;
        for (int i = 1; i < RD_LAT; i++) ra[i] <= ra[i-1];
    end
    assign dout1 = mem[ra[RD_LAT-1]];

    function automatic logic [DATA_W-1:0] golden(input int a);
        if (a == 5) return 32'hDEADBEEF;
        return 32'hA500_0000 + 32'(a);
    endfunction

    typedef struct {
        logic rst, en, r0, r1;
        logic [ADDR_W-1:0] a0, a1;
        logic g0, g1, csb, rv0, rv1, bsy;
        logic [ADDR_W-1:0] ad;
        logic [DATA_W-1:0] rd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_v, en_v, r0_v, input int a0_v, input logic r1_v, input int a1_v,
                       input logic g0_v, g1_v, csb_v, input int ad_v,
                       input logic rv0_v, rv1_v, bsy_v, input logic [DATA_W-1:0] rd_v);
        vec_t v;
        v.rst = rst_v; v.en = en_v; v.r0 = r0_v; v.a0 = ADDR_W'(a0_v); v.r1 = r1_v; v.a1 = ADDR_W'(a1_v);
        v.g0 = g0_v; v.g1 = g1_v; v.csb = csb_v; v.ad = ADDR_W'(ad_v);
        v.rv0 = rv0_v; v.rv1 = rv1_v; v.bsy = bsy_v; v.rd = rd_v;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Random-phase reference model.
    logic m_v [RD_LAT];
    logic m_o [RD_LAT];
    logic [ADDR_W-1:0] m_a [RD_LAT];
    logic m_last;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = golden(i);
        rst = 1'b1; en = 1'b0; req0 = 1'b0; req1 = 1'b0; a0 = '0; a1 = '0;

        // T1 plus reset state (requests held during reset must not be granted)
        add(1,1,1,5,1,7,      0,0,1,0,     0,0,0, 0);
        add(0,1,1,5,0,0,      1,0,0,5,     0,0,0, 0);
        add(0,1,0,0,0,0,      0,0,1,0,     1,0,1, 32'hDEADBEEF);
        add(0,1,0,0,0,0,      0,0,1,0,     0,0,0, 0);
        // T3 back-to-back requester 1
        for (int k = 0; k < 4; k++)
            add(0,1,0,0,1,'h10+k, 0,1,0,'h10+k, 0,(k>0),(k>0), golden('h10+k-1));
        // T2 contention, last grant was requester 1
`ifdef WFG_MEM_ARB_RR_EN
        add(0,1,1,'h20,1,'h30, 1,0,0,'h20, 0,1,1, golden('h13));
        add(0,1,1,'h20,1,'h30, 0,1,0,'h30, 1,0,1, golden('h20));
        add(0,1,1,'h20,1,'h30, 1,0,0,'h20, 0,1,1, golden('h30));
        add(0,1,1,'h20,1,'h30, 0,1,0,'h30, 1,0,1, golden('h20));
        add(0,1,0,0,0,0,       0,0,1,0,    0,1,1, golden('h30));
`else
        add(0,1,1,'h20,1,'h30, 1,0,0,'h20, 0,1,1, golden('h13));
        for (int k = 0; k < 3; k++)
            add(0,1,1,'h20,1,'h30, 1,0,0,'h20, 1,0,1, golden('h20));
        add(0,1,0,0,0,0,       0,0,1,0,    1,0,1, golden('h20));
`endif
        add(0,1,0,0,0,0,      0,0,1,0,     0,0,0, 0);
        // T4 enable low blocks grants; dropping it after a grant still drains
        add(0,0,1,3,0,0,      0,0,1,0,     0,0,0, 0);
        add(0,1,1,3,0,0,      1,0,0,3,     0,0,0, 0);
        add(0,0,1,3,0,0,      0,0,1,0,     1,0,1, golden(3));
        add(0,0,1,3,0,0,      0,0,1,0,     0,0,0, 0);
        // T5 reset the cycle after a grant flushes the read; last_gnt returns to 1
        add(0,1,1,9,0,0,      1,0,0,9,     0,0,0, 0);
        add(1,1,1,9,0,0,      0,0,1,0,     0,0,0, 0);
        add(0,0,0,0,0,0,      0,0,1,0,     0,0,0, 0);
        add(0,1,1,4,1,6,      1,0,0,4,     0,0,0, 0);
        add(0,1,0,0,0,0,      0,0,1,0,     1,0,1, golden(4));
        add(0,1,0,0,0,0,      0,0,1,0,     0,0,0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; en = vecs[i].en;
            req0 = vecs[i].r0; a0 = vecs[i].a0; req1 = vecs[i].r1; a1 = vecs[i].a1;
            #1;
            chk($sformatf("v%0d gnt0", i),  {31'b0, gnt0}, {31'b0, vecs[i].g0});
            chk($sformatf("v%0d gnt1", i),  {31'b0, gnt1}, {31'b0, vecs[i].g1});
            chk($sformatf("v%0d csb1", i),  {31'b0, csb1}, {31'b0, vecs[i].csb});
            chk($sformatf("v%0d addr1", i), {22'b0, sram_addr}, {22'b0, vecs[i].ad});
            chk($sformatf("v%0d rvalid0", i), {31'b0, rv0}, {31'b0, vecs[i].rv0});
            chk($sformatf("v%0d rvalid1", i), {31'b0, rv1}, {31'b0, vecs[i].rv1});
            chk($sformatf("v%0d busy", i),  {31'b0, busy}, {31'b0, vecs[i].bsy});
            if (vecs[i].rv0 || vecs[i].rv1)
                chk($sformatf("v%0d rdata", i), rdata, vecs[i].rd);
        end

        // T6 random traffic against the model, starting from a fresh reset
        @(negedge clk);
        rst = 1'b1; en = 1'b0; req0 = 1'b0; req1 = 1'b0;
        m_last = 1'b1;
        for (int i = 0; i < RD_LAT; i++) begin m_v[i] = 1'b0; m_o[i] = 1'b0; m_a[i] = '0; end
        for (int c = 0; c < 3000; c++) begin
            logic ei, s1, ebusy;
            @(negedge clk);
            rst  = 1'b0;
            en   = ($urandom_range(0, 9) != 0);
            req0 = 1'($urandom_range(0, 1));
            req1 = 1'($urandom_range(0, 1));
            a0   = ADDR_W'($urandom_range(0, 1023));
            a1   = ADDR_W'($urandom_range(0, 1023));
            #1;
            ei = en & (req0 | req1);
`ifdef WFG_MEM_ARB_RR_EN
            s1 = req1 & (!req0 || (m_last == 1'b0));
`else
            s1 = req1 & !req0;
`endif
            ebusy = 1'b0;
            for (int i = 0; i < RD_LAT; i++) ebusy |= m_v[i];
            chk("rnd gnt0", {31'b0, gnt0}, {31'b0, ei & ~s1});
            chk("rnd gnt1", {31'b0, gnt1}, {31'b0, ei & s1});
            chk("rnd gnt_excl", {31'b0, gnt0 & gnt1}, 32'd0);
            chk("rnd csb1", {31'b0, csb1}, {31'b0, ~ei});
            chk("rnd addr1", {22'b0, sram_addr}, ei ? {22'b0, (s1 ? a1 : a0)} : 32'd0);
            chk("rnd rvalid0", {31'b0, rv0}, {31'b0, m_v[RD_LAT-1] & ~m_o[RD_LAT-1]});
            chk("rnd rvalid1", {31'b0, rv1}, {31'b0, m_v[RD_LAT-1] &  m_o[RD_LAT-1]});
            chk("rnd busy", {31'b0, busy}, {31'b0, ebusy});
            if (m_v[RD_LAT-1]) chk("rnd rdata", rdata, golden(int'(m_a[RD_LAT-1])));
            for (int i = RD_LAT-1; i > 0; i--) begin
                m_v[i] = m_v[i-1]; m_o[i] = m_o[i-1]; m_a[i] = m_a[i-1];
            end
            m_v[0] = ei; m_o[0] = s1; m_a[0] = s1 ? a1 : a0;
            if (ei) m_last = s1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
